tsbus_arbiter: RTL and testbench

Round-robin arbiter that shares one tri-state bus between N requesters by driving the enable inputs of their tri-state drivers (notif1-style cells). It guarantees at most one enable high at any time, bounds how long one requester may hold the bus, and inserts a break-before-make turnaround gap between owners so two drivers never fight on the bus. It sits between the requesting units and the shared-bus driver cells.

---
 rtl/tsbus_pkg.sv | 19 +
 rtl/rr_pick.sv | 30 +++
 rtl/tsbus_arbiter.sv | 113 +++++++++++
 tb/tb_tsbus_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/tsbus_pkg.sv
// rtl/tsbus_pkg.sv - shared types and defaults for the tri-state bus arbiter
package tsbus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  localparam int N_DEF        = 4;
  localparam int MAX_HOLD_DEF = 8;
  localparam int TURN_CYC_DEF = 1;

  // Width needed to index/count v distinct values; never below one bit.
  function automatic int cw(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first set request from ptr upward
module rr_pick
  import tsbus_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = cw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] winner
);

  logic [IW-1:0] idx;

  // Walk from the farthest offset back toward ptr so the nearest hit wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/tsbus_arbiter.sv
// rtl/tsbus_arbiter.sv - round-robin tri-state bus arbiter with hold limit and turnaround gap
module tsbus_arbiter
  import tsbus_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  output logic [N-1:0]        en,
  output logic [cw(N)-1:0]    gnt_id,
  output logic                bus_busy
);

  localparam int IW = cw(N);
  localparam int HW = cw(MAX_HOLD + 1);
  localparam int TW = cw(TURN_CYC + 1);

  state_t        state, state_n;
  logic [N-1:0]  en_n;
  logic [IW-1:0] gnt_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [TW-1:0] turn_cnt, turn_n;
  logic          busy_n;
  logic          pick_any;
  logic [IW-1:0] pick_id;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_id)
  );

  always_comb begin
    state_n = state;
    en_n    = en;
    gnt_n   = gnt_id;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    turn_n  = turn_cnt;
    case (state)
      IDLE: begin
        en_n  = '0;
        gnt_n = '0;
        if (pick_any) begin
          state_n = GRANT;
          en_n    = N'(1) << pick_id;
          gnt_n   = pick_id;
          hold_n  = '0;
          ptr_n   = (pick_id == IW'(N - 1)) ? '0 : pick_id + IW'(1);
        end
      end
      GRANT: begin
        if (!req[gnt_id] || hold_cnt == HW'(MAX_HOLD - 1)) begin
          state_n = TURN;
          en_n    = '0;
          turn_n  = '0;
        end else begin
          hold_n = hold_cnt + HW'(1);
        end
      end
      TURN: begin
        en_n = '0;
        // gnt_id keeps the previous owner until the next arbitration point.
        if (turn_cnt == TW'(TURN_CYC - 1)) begin
          if (pick_any) begin
            state_n = GRANT;
            en_n    = N'(1) << pick_id;
            gnt_n   = pick_id;
            hold_n  = '0;
            ptr_n   = (pick_id == IW'(N - 1)) ? '0 : pick_id + IW'(1);
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end else begin
          turn_n = turn_cnt + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        en_n    = '0;
        gnt_n   = '0;
      end
    endcase
    busy_n = |en_n;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      en       <= '0;
      gnt_id   <= '0;
      bus_busy <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= state_n;
      en       <= en_n;
      gnt_id   <= gnt_n;
      bus_busy <= busy_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      turn_cnt <= turn_n;
    end
  end

endmodule

// File: tb/tb_tsbus_arbiter.sv
// tb/tb_tsbus_arbiter.sv - scoreboard bench for tsbus_arbiter (N=4, MAX_HOLD=8, TURN_CYC=1)
module tb_tsbus_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [3:0] en;
    logic [1:0] gid;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] en;
  logic [1:0] gnt_id;
  logic       bus_busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [3:0] prev_en = '0;

  tsbus_arbiter #(.N(N), .MAX_HOLD(8), .TURN_CYC(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .en       (en),
    .gnt_id   (gnt_id),
    .bus_busy (bus_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue the outputs expected after the edge, then compare.
  task automatic step(input logic rv, input logic [3:0] r, input logic [3:0] e, input logic [1:0] g);
    exp_t x;
    @(negedge clk);
    rst = rv;
    req = r;
    exp_q.push_back('{en: e, gid: g});
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("en", 32'(en), 32'(x.en));
    chk("gnt_id", 32'(gnt_id), 32'(x.gid));
    chk("bus_busy", 32'(bus_busy), 32'(x.en != 4'b0));
    chk("onehot", 32'($countones(en) <= 1), 32'd1);
    chk("bbm", 32'(prev_en != 4'b0 && en != 4'b0 && en != prev_en), 32'd0);
    prev_en = en;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every line requesting.
    step(1'b0, 4'b1111, 4'b0000, 2'd0);
    step(1'b0, 4'b1111, 4'b0000, 2'd0);
    step(1'b1, 4'b1111, 4'b0001, 2'd0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0);

    // Re-grant of a lone requester after hitting the hold limit (ptr=1).
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0010, 4'b0010, 2'd1);
    step(1'b1, 4'b0010, 4'b0000, 2'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0010, 4'b0010, 2'd1);
    step(1'b1, 4'b0000, 4'b0000, 2'd1);
    step(1'b1, 4'b0000, 4'b0000, 2'd0);

    // Single requester for three cycles (ptr=2).
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0100, 4'b0100, 2'd2);
    step(1'b1, 4'b0000, 4'b0000, 2'd2);
    step(1'b1, 4'b0000, 4'b0000, 2'd0);

    // Wrap-around: ptr=3, lines 3 and 0 requesting.
    step(1'b1, 4'b1001, 4'b1000, 2'd3);
    step(1'b1, 4'b0001, 4'b0000, 2'd3);
    step(1'b1, 4'b0001, 4'b0001, 2'd0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0);
    step(1'b1, 4'b0000, 4'b0000, 2'd0);

    // Hold limit alternation between lines 1 and 0 (ptr=1).
    for (int r = 0; r < 4; r++) begin
      logic [1:0] o;
      o = (r % 2 == 0) ? 2'd1 : 2'd0;
      for (int i = 0; i < 8; i++) step(1'b1, 4'b0011, 4'(1) << o, o);
      step(1'b1, 4'b0011, 4'b0000, o);
    end
    step(1'b1, 4'b0000, 4'b0000, 2'd0);

    // Reset in the middle of a grant to line 3.
    step(1'b1, 4'b1000, 4'b1000, 2'd3);
    step(1'b1, 4'b1000, 4'b1000, 2'd3);
    step(1'b0, 4'b1010, 4'b0000, 2'd0);
    step(1'b1, 4'b1010, 4'b0010, 2'd1);
    step(1'b1, 4'b0000, 4'b0000, 2'd1);
    step(1'b1, 4'b0000, 4'b0000, 2'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
